// File: rtl/poly_mac_engine.sv
//-----------------------------------------------------------------------------
// poly_mac_engine
//
// Self-sequencing multiply-accumulate engine for a polyphase decimating FIR.
// The engine owns a TAPS-deep sample ring and a TAPS-deep coefficient RAM.
// Samples arrive over a valid/ready handshake. After every DECIM accepted
// samples it runs one full convolution over the ring, then rounds and
// saturates the accumulator into a signed OUT_SIZE result. The result is
// offered over a valid/ready handshake.
//
// Ports
//   clk      : clock, all logic on the rising edge
//   nrst     : asynchronous active-low reset
//   flush    : single-cycle request in IDLE to zero the sample history
//   c_we     : coefficient write strobe (honoured in IDLE only)
//   c_addr   : coefficient index, 0 multiplies the newest sample
//   c_din    : coefficient data
//   c_busy   : high whenever the engine is not in IDLE
//   s_din    : input sample
//   s_valid  : input sample valid
//   s_ready  : engine can take a sample this cycle
//   y_dout   : rounded and saturated filter output
//   y_sat    : y_dout was clipped
//   y_valid  : output valid
//   y_ready  : downstream accepts the output
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module poly_mac_engine #(
   parameter int TAPS        = 43,
   parameter int SAMPLE_SIZE = 16,
   parameter int COEFF_SIZE  = 16,
   parameter int DECIM       = 4,
   parameter int OUT_SHIFT   = 15,
   parameter int OUT_SIZE    = 16
) (
   input  logic                          clk,
   input  logic                          nrst,
   input  logic                          flush,
   input  logic                          c_we,
   input  logic [$clog2(TAPS)-1:0]       c_addr,
   input  logic signed [COEFF_SIZE-1:0]  c_din,
   output logic                          c_busy,
   input  logic signed [SAMPLE_SIZE-1:0] s_din,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic signed [OUT_SIZE-1:0]    y_dout,
   output logic                          y_sat,
   output logic                          y_valid,
   input  logic                          y_ready
);

   localparam int AW   = $clog2(TAPS);
   localparam int PHW  = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int PW   = SAMPLE_SIZE + COEFF_SIZE;
   localparam int ACCW = PW + AW;
   localparam int RW   = ACCW + 1;

   localparam logic [AW-1:0]  LAST_ADDR = AW'(TAPS - 1);
   localparam logic [PHW-1:0] LAST_PH   = PHW'(DECIM - 1);

   localparam logic signed [RW-1:0] RND  = RW'(1) << (OUT_SHIFT - 1);
   localparam logic signed [RW-1:0] OMAX = {{(RW - OUT_SIZE + 1){1'b0}}, {(OUT_SIZE - 1){1'b1}}};
   localparam logic signed [RW-1:0] OMIN = {{(RW - OUT_SIZE + 1){1'b1}}, {(OUT_SIZE - 1){1'b0}}};

   typedef enum logic [2:0] {
      ST_CLR,
      ST_IDLE,
      ST_MAC,
      ST_DRAIN,
      ST_ROUND,
      ST_OUT
   } state_t;

   state_t r_state;
   state_t w_stateNext;

   logic [AW-1:0]  r_clrCnt;
   logic [AW-1:0]  r_wp;
   logic [AW-1:0]  r_rp;
   logic [AW-1:0]  r_k;
   logic [PHW-1:0] r_ph;

   logic signed [ACCW-1:0]     r_acc;
   logic signed [OUT_SIZE-1:0] r_yDout;
   logic                       r_ySat;
   logic                       r_yValid;

   logic signed [SAMPLE_SIZE-1:0] r_sampleMem [TAPS];
   logic signed [COEFF_SIZE-1:0]  r_coeffMem  [TAPS];
   logic signed [SAMPLE_SIZE-1:0] r_sRd;
   logic signed [COEFF_SIZE-1:0]  r_cRd;

   logic                          w_accept;
   logic                          w_phaseEnd;
   logic                          w_cWrite;
   logic                          w_sWe;
   logic [AW-1:0]                 w_sWaddr;
   logic signed [SAMPLE_SIZE-1:0] w_sWdata;

   logic signed [PW-1:0]       w_prod;
   logic signed [ACCW-1:0]     w_prodExt;
   logic signed [RW-1:0]       w_accExt;
   logic signed [RW-1:0]       w_sum;
   logic signed [RW-1:0]       w_shifted;
   logic                       w_satHi;
   logic                       w_satLo;
   logic signed [OUT_SIZE-1:0] w_yNext;

   // A sample is taken only in IDLE and only when no flush is pending in the
   // same cycle; flush always has priority over a simultaneous sample.
   always_comb begin
      w_accept   = (r_state == ST_IDLE) && s_valid && !flush;
      w_phaseEnd = w_accept && (r_ph == LAST_PH);
      w_cWrite   = (r_state == ST_IDLE) && c_we;
   end

   // The sample ring has a single write port shared by the clear sweep and
   // by accepted samples; the two never happen in the same state.
   always_comb begin
      w_sWe    = 1'b0;
      w_sWaddr = r_wp;
      w_sWdata = s_din;
      if (r_state == ST_CLR) begin
         w_sWe    = 1'b1;
         w_sWaddr = r_clrCnt;
         w_sWdata = '0;
      end else if (w_accept) begin
         w_sWe    = 1'b1;
         w_sWaddr = r_wp;
         w_sWdata = s_din;
      end
   end

   // Both RAMs have a registered read port. The read address for the ring is
   // a down-counting pointer starting at the newest sample, and the
   // coefficient address is the tap index, so the product of tap k lines up
   // one cycle after tap k is issued. A sample written on one edge is visible
   // to a read on the next edge, so no bypass is needed.
   always_ff @(posedge clk) begin
      if (w_sWe) begin
         r_sampleMem[w_sWaddr] <= w_sWdata;
      end
      if (w_cWrite) begin
         r_coeffMem[c_addr] <= c_din;
      end
      r_sRd <= r_sampleMem[r_rp];
      r_cRd <= r_coeffMem[r_k];
   end

   // Full-precision product, sign-extended to the accumulator width. The
   // accumulator carries clog2(TAPS) guard bits so a full convolution of
   // extreme values cannot wrap.
   always_comb begin
      w_prod    = PW'(r_sRd) * PW'(r_cRd);
      w_prodExt = {{AW{w_prod[PW-1]}}, w_prod};
   end

   // Round half up by adding half an LSB of the output scale, then
   // arithmetic shift. One extra bit keeps the rounding add from wrapping.
   // Anything outside the signed OUT_SIZE range is clamped and flagged.
   always_comb begin
      w_accExt  = {r_acc[ACCW-1], r_acc};
      w_sum     = w_accExt + RND;
      w_shifted = w_sum >>> OUT_SHIFT;
      w_satHi   = w_shifted > OMAX;
      w_satLo   = w_shifted < OMIN;
      w_yNext   = w_shifted[OUT_SIZE-1:0];
      if (w_satHi) begin
         w_yNext = OMAX[OUT_SIZE-1:0];
      end else if (w_satLo) begin
         w_yNext = OMIN[OUT_SIZE-1:0];
      end
   end

   // State register. Reset always lands in CLR so the history is zeroed
   // before any sample is taken.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= ST_CLR;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state logic: clear sweep, wait for a full phase of samples, run
   // TAPS MAC cycles, one drain cycle for the last product, one rounding
   // cycle, then hold the result until it is taken.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_CLR: begin
            if (r_clrCnt == LAST_ADDR) begin
               w_stateNext = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (flush) begin
               w_stateNext = ST_CLR;
            end else if (w_phaseEnd) begin
               w_stateNext = ST_MAC;
            end
         end
         ST_MAC: begin
            if (r_k == LAST_ADDR) begin
               w_stateNext = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            w_stateNext = ST_ROUND;
         end
         ST_ROUND: begin
            w_stateNext = ST_OUT;
         end
         ST_OUT: begin
            if (y_ready) begin
               w_stateNext = ST_IDLE;
            end
         end
         default: begin
            w_stateNext = ST_CLR;
         end
      endcase
   end

   // Datapath registers. Pointers and the phase counter only move in IDLE;
   // the accumulator is cleared on the sample that completes a phase and
   // skips the first MAC cycle because the RAM read for tap 0 is still in
   // flight. y_valid is cleared asynchronously by reset so a result cut off
   // by reset is never presented.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_clrCnt <= '0;
         r_wp     <= '0;
         r_rp     <= '0;
         r_k      <= '0;
         r_ph     <= '0;
         r_acc    <= '0;
         r_yDout  <= '0;
         r_ySat   <= 1'b0;
         r_yValid <= 1'b0;
      end else begin
         case (r_state)
            ST_CLR: begin
               r_clrCnt <= (r_clrCnt == LAST_ADDR) ? '0 : r_clrCnt + AW'(1);
            end
            ST_IDLE: begin
               if (flush) begin
                  r_wp     <= '0;
                  r_ph     <= '0;
                  r_clrCnt <= '0;
               end else if (w_accept) begin
                  r_wp <= (r_wp == LAST_ADDR) ? '0 : r_wp + AW'(1);
                  r_rp <= r_wp;
                  if (r_ph == LAST_PH) begin
                     r_ph  <= '0;
                     r_acc <= '0;
                     r_k   <= '0;
                  end else begin
                     r_ph <= r_ph + PHW'(1);
                  end
               end
            end
            ST_MAC: begin
               if (r_k != '0) begin
                  r_acc <= r_acc + w_prodExt;
               end
               if (r_k != LAST_ADDR) begin
                  r_k <= r_k + AW'(1);
               end
               r_rp <= (r_rp == '0) ? LAST_ADDR : r_rp - AW'(1);
            end
            ST_DRAIN: begin
               r_acc <= r_acc + w_prodExt;
            end
            ST_ROUND: begin
               r_yDout  <= w_yNext;
               r_ySat   <= w_satHi || w_satLo;
               r_yValid <= 1'b1;
            end
            ST_OUT: begin
               if (y_ready) begin
                  r_yValid <= 1'b0;
               end
            end
            default: begin
               r_yValid <= 1'b0;
            end
         endcase
      end
   end

   // Handshake outputs follow the state directly so they drop with reset.
   always_comb begin
      c_busy  = (r_state != ST_IDLE);
      s_ready = (r_state == ST_IDLE);
      y_dout  = r_yDout;
      y_sat   = r_ySat;
      y_valid = r_yValid;
   end

endmodule

// File: tb/tb_poly_mac_engine.sv
//-----------------------------------------------------------------------------
// tb_poly_mac_engine
//
// Two engines share clock and reset. Engine A (TAPS=4, DECIM=2, OUT_SHIFT=1)
// is driven against a behavioural convolution model whose expected results
// are queued when the phase-completing sample is driven and popped when the
// engine presents an output. Engine B (TAPS=4, DECIM=1, OUT_SHIFT=2, single
// non-zero tap) exercises rounding of positive and negative accumulators.
// All inputs change and all outputs are sampled on the falling edge.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_poly_mac_engine;

   localparam int TAPS       = 4;
   localparam int DECIM      = 2;
   localparam int SHIFT      = 1;
   localparam int WAIT_LIMIT = 200;

   typedef struct {
      int value;
      bit sat;
   } expect_t;

   logic clk = 1'b0;
   logic nrst;

   logic               flush, cWe, sValid, yReady;
   logic [1:0]         cAddr;
   logic signed [15:0] cDin, sDin, yDout;
   logic               cBusy, sReady, ySat, yValid;

   logic               bCWe, bSValid, bYReady;
   logic [1:0]         bCAddr;
   logic signed [15:0] bCDin, bSDin, bYDout;
   logic               bCBusy, bSReady, bYSat, bYValid;

   int checkCount = 0;
   int passCount  = 0;

   expect_t scoreboard[$];
   expect_t bScoreboard[$];

   int mHist  [TAPS];
   int mCoeff [TAPS];
   int mWp;
   int mPh;

   always #5 clk = ~clk;

   poly_mac_engine #(
      .TAPS(TAPS), .SAMPLE_SIZE(16), .COEFF_SIZE(16),
      .DECIM(DECIM), .OUT_SHIFT(SHIFT), .OUT_SIZE(16)
   ) dutA (
      .clk(clk), .nrst(nrst), .flush(flush),
      .c_we(cWe), .c_addr(cAddr), .c_din(cDin), .c_busy(cBusy),
      .s_din(sDin), .s_valid(sValid), .s_ready(sReady),
      .y_dout(yDout), .y_sat(ySat), .y_valid(yValid), .y_ready(yReady)
   );

   poly_mac_engine #(
      .TAPS(4), .SAMPLE_SIZE(16), .COEFF_SIZE(16),
      .DECIM(1), .OUT_SHIFT(2), .OUT_SIZE(16)
   ) dutB (
      .clk(clk), .nrst(nrst), .flush(1'b0),
      .c_we(bCWe), .c_addr(bCAddr), .c_din(bCDin), .c_busy(bCBusy),
      .s_din(bSDin), .s_valid(bSValid), .s_ready(bSReady),
      .y_dout(bYDout), .y_sat(bYSat), .y_valid(bYValid), .y_ready(bYReady)
   );

   // Counts every comparison and reports mismatches on one line.
   task automatic checkOutput(input string tag, input longint actual, input longint expected);
      checkCount++;
      if (actual == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Zeroes the model history, as CLR does in the engine.
   task automatic modelClear();
      for (int i = 0; i < TAPS; i++) mHist[i] = 0;
      mWp = 0;
      mPh = 0;
   endtask

   // Records an accepted sample; on phase completion computes the rounded,
   // saturated convolution and queues it.
   task automatic modelAccept(input int s);
      int     newest;
      longint acc;
      longint r;
      expect_t e;
      mHist[mWp] = s;
      newest = mWp;
      mWp = (mWp + 1) % TAPS;
      mPh++;
      if (mPh == DECIM) begin
         mPh = 0;
         acc = 0;
         for (int k = 0; k < TAPS; k++) begin
            acc += longint'(mHist[(newest - k + TAPS) % TAPS]) * longint'(mCoeff[k]);
         end
         r = (acc + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
         e.sat = 1'b0;
         if (r > 32767) begin
            r = 32767;
            e.sat = 1'b1;
         end else if (r < -32768) begin
            r = -32768;
            e.sat = 1'b1;
         end
         e.value = int'(r);
         scoreboard.push_back(e);
      end
   endtask

   task automatic writeCoeff(input int addr, input int val);
      cWe   = 1'b1;
      cAddr = 2'(addr);
      cDin  = 16'(val);
      @(negedge clk);
      cWe = 1'b0;
      mCoeff[addr] = val;
   endtask

   // Drives one sample once the engine is ready; returns on the falling
   // edge after the accepting edge.
   task automatic applyStimulus(input int s);
      int cnt = 0;
      while (!sReady && cnt < WAIT_LIMIT) begin
         @(negedge clk);
         cnt++;
      end
      if (!sReady) checkOutput("sReady_timeout", sReady, 1);
      sDin   = 16'(s);
      sValid = 1'b1;
      modelAccept(s);
      @(negedge clk);
      sValid = 1'b0;
   endtask

   // Bounded wait for y_valid; cnt starts at 1 because the caller enters one
   // cycle after the accepting edge.
   task automatic waitValid(input string tag, output int cnt);
      cnt = 1;
      while (!yValid && cnt < WAIT_LIMIT) begin
         @(negedge clk);
         cnt++;
      end
      if (!yValid) checkOutput({tag, "_timeout"}, yValid, 1);
   endtask

   task automatic collectOutput(input string tag, input int expectLat);
      int      cnt;
      expect_t e;
      waitValid(tag, cnt);
      if (!yValid) return;
      if (expectLat > 0) checkOutput({tag, "_latency"}, cnt, expectLat);
      if (scoreboard.size() == 0) begin
         checkOutput({tag, "_sbDepth"}, scoreboard.size(), 1);
         return;
      end
      e = scoreboard.pop_front();
      checkOutput({tag, "_yDout"}, yDout, e.value);
      checkOutput({tag, "_ySat"}, ySat, e.sat);
      yReady = 1'b1;
      @(negedge clk);
      yReady = 1'b0;
      checkOutput({tag, "_yValidDrop"}, yValid, 0);
   endtask

   task automatic bWriteCoeff(input int addr, input int val);
      bCWe   = 1'b1;
      bCAddr = 2'(addr);
      bCDin  = 16'(val);
      @(negedge clk);
      bCWe = 1'b0;
   endtask

   task automatic bRoundCase(input int s, input int expected);
      int      cnt = 0;
      expect_t e;
      while (!bSReady && cnt < WAIT_LIMIT) begin
         @(negedge clk);
         cnt++;
      end
      bSDin   = 16'(s);
      bSValid = 1'b1;
      e.value = expected;
      e.sat   = 1'b0;
      bScoreboard.push_back(e);
      @(negedge clk);
      bSValid = 1'b0;
      cnt = 0;
      while (!bYValid && cnt < WAIT_LIMIT) begin
         @(negedge clk);
         cnt++;
      end
      if (!bYValid) begin
         checkOutput("round_timeout", bYValid, 1);
         return;
      end
      e = bScoreboard.pop_front();
      checkOutput($sformatf("round_%0d_yDout", s), bYDout, e.value);
      checkOutput($sformatf("round_%0d_ySat", s), bYSat, e.sat);
      bYReady = 1'b1;
      @(negedge clk);
      bYReady = 1'b0;
   endtask

   // Safety net so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checkCount);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cnt;
      int roundIn  [3] = '{6, -6, 5};
      int roundOut [3] = '{2, -1, 1};

      nrst   = 1'b0;
      flush  = 1'b0; cWe = 1'b0; cAddr = '0; cDin = '0;
      sDin   = '0;   sValid = 1'b0; yReady = 1'b0;
      bCWe   = 1'b0; bCAddr = '0; bCDin = '0;
      bSDin  = '0;   bSValid = 1'b0; bYReady = 1'b0;
      for (int i = 0; i < TAPS; i++) mCoeff[i] = 0;
      modelClear();

      // Reset state, then exactly TAPS cycles of clear sweep.
      repeat (3) @(negedge clk);
      checkOutput("rst_yValid", yValid, 0);
      checkOutput("rst_yDout", yDout, 0);
      checkOutput("rst_ySat", ySat, 0);
      checkOutput("rst_cBusy", cBusy, 1);
      checkOutput("rst_sReady", sReady, 0);
      nrst = 1'b1;
      for (int i = 1; i <= TAPS; i++) begin
         @(negedge clk);
         checkOutput($sformatf("clr_sReady_%0d", i), sReady, (i == TAPS) ? 1 : 0);
         checkOutput($sformatf("clr_cBusy_%0d", i), cBusy, (i == TAPS) ? 0 : 1);
         checkOutput($sformatf("clr_yValid_%0d", i), yValid, 0);
      end

      // Basic convolution and latency.
      writeCoeff(0, 2); writeCoeff(1, 4); writeCoeff(2, 6); writeCoeff(3, 8);
      applyStimulus(10);
      applyStimulus(20);
      checkOutput("mac_cBusy", cBusy, 1);
      checkOutput("mac_sReady", sReady, 0);
      collectOutput("basic1", TAPS + 3);

      // Backpressure: output held, no sample taken while OUT is pending.
      applyStimulus(30);
      applyStimulus(40);
      waitValid("bp", cnt);
      for (int i = 0; i < 20; i++) begin
         sValid = (i == 5);
         sDin   = 16'sd999;
         @(negedge clk);
         checkOutput($sformatf("bp_yDout_%0d", i), yDout, scoreboard.size() > 0 ? scoreboard[0].value : 0);
         checkOutput($sformatf("bp_sReady_%0d", i), sReady, 0);
         checkOutput($sformatf("bp_yValid_%0d", i), yValid, 1);
      end
      sValid = 1'b0;
      collectOutput("bp", -1);

      // Coefficient write during MAC must be dropped.
      applyStimulus(50);
      applyStimulus(60);
      cWe = 1'b1; cAddr = 2'd0; cDin = 16'sd100;
      @(negedge clk);
      cWe = 1'b0;
      collectOutput("dropCwe", -1);
      applyStimulus(1);
      applyStimulus(2);
      collectOutput("afterDrop", -1);

      // Saturation at both rails.
      for (int i = 0; i < TAPS; i++) writeCoeff(i, 32767);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(32767);
         if (i % 2 == 1) collectOutput($sformatf("satHi_%0d", i), -1);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(-32768);
         if (i % 2 == 1) collectOutput($sformatf("satLo_%0d", i), -1);
      end

      // Reset in the middle of MAC discards the partial result.
      writeCoeff(0, 2); writeCoeff(1, 4); writeCoeff(2, 6); writeCoeff(3, 8);
      applyStimulus(11);
      applyStimulus(12);
      @(negedge clk);
      @(negedge clk);
      #2 nrst = 1'b0;
      #1;
      checkOutput("macRst_yValid", yValid, 0);
      checkOutput("macRst_cBusy", cBusy, 1);
      scoreboard.delete();
      modelClear();
      @(negedge clk);
      nrst = 1'b1;
      applyStimulus(5);
      applyStimulus(7);
      collectOutput("postReset", TAPS + 3);

      // Reset while an output is pending drops y_valid at once.
      applyStimulus(3);
      applyStimulus(4);
      waitValid("outRst", cnt);
      #2 nrst = 1'b0;
      #1;
      checkOutput("outRst_yValid", yValid, 0);
      checkOutput("outRst_yDout", yDout, 0);
      scoreboard.delete();
      modelClear();
      @(negedge clk);
      nrst = 1'b1;

      // Flush with a simultaneous sample: flush wins, history and phase zero.
      applyStimulus(50);
      flush  = 1'b1;
      sValid = 1'b1;
      sDin   = 16'sd1234;
      @(negedge clk);
      flush  = 1'b0;
      sValid = 1'b0;
      checkOutput("flush_cBusy", cBusy, 1);
      modelClear();
      applyStimulus(1);
      applyStimulus(1);
      collectOutput("flush", TAPS + 3);

      // Rounding on engine B: accumulator equals the newest sample.
      bWriteCoeff(0, 1); bWriteCoeff(1, 0); bWriteCoeff(2, 0); bWriteCoeff(3, 0);
      for (int i = 0; i < 3; i++) bRoundCase(roundIn[i], roundOut[i]);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/poly_mac_engine.md
# poly_mac_engine

Self-sequencing multiply-accumulate engine for the polyphase decimating FIR path. It holds a TAPS-deep sample ring and a coefficient RAM, and accepts samples over a valid/ready handshake. After every DECIM accepted samples it runs a full TAPS-cycle convolution, then rounds and saturates the result to OUT_SIZE. It replaces externally addressed MAC slices, so the controller supplies only samples and coefficients.

## Interface
- TAPS, 43: filter length; depth of both RAMs.
- SAMPLE_SIZE, 16: signed sample width.
- COEFF_SIZE, 16: signed coefficient width.
- DECIM, 4: accepted samples per output, ≥1.
- OUT_SHIFT, 15: right shift applied to the accumulator before output, ≥1.
- OUT_SIZE, 16: signed output width.
- clk  in  1  clock; all logic on rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- flush  in  1  in IDLE, single-cycle request to zero the sample history.
- c_we  in  1  coefficient write strobe.
- c_addr  in  $clog2(TAPS)  coefficient index; 0 multiplies the newest sample.
- c_din  in  COEFF_SIZE  coefficient data.
- c_busy  out  1  high when state ≠ IDLE.
- s_din  in  SAMPLE_SIZE  input sample.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample ready.
- y_dout  out  OUT_SIZE  filtered output.
- y_sat  out  1  y_dout was clipped.
- y_valid  out  1  output valid.
- y_ready  in  1  output accepted.

## Operation
- States: CLR, IDLE, MAC, DRAIN, ROUND, OUT.
- Reset: state = CLR. Clear counter, wp, ph, acc, y_dout, y_sat and y_valid all go to 0. c_busy = 1 and s_ready = 0.
- CLR: writes 0 to sample address 0..TAPS-1, one per cycle. After TAPS cycles → IDLE. flush in IDLE → CLR, with wp = 0 and ph = 0.
- IDLE: s_ready = 1. On s_valid && s_ready:
  - s_din is written at wp.
  - wp advances and wraps from TAPS-1 to 0.
  - ph advances. If ph was DECIM-1, then ph = 0 and the state goes to MAC with acc = 0.
- If flush and s_valid are high together in IDLE, flush wins and the sample is not accepted.
- c_we is honoured only in IDLE. In every other state it is silently dropped.
- MAC: lasts TAPS cycles, k = 0..TAPS-1.
  - Issues sample address (newest − k) mod TAPS and coefficient address k.
  - RAMs have 1-cycle synchronous read.
  - From the second MAC cycle, acc += sign-extended s×c.
- DRAIN: 1 cycle; accumulates the last product.
- ROUND: 1 cycle.
  - r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT.
  - If r exceeds the OUT_SIZE signed range, clamp to max/min and set y_sat = 1; else y_sat = 0.
  - Register into y_dout.
- OUT: y_valid = 1. y_dout and y_sat are held until y_ready, then y_valid = 0 in the same edge and the state goes to IDLE.
- Widths:
  - Product is SAMPLE_SIZE+COEFF_SIZE signed, full precision.
  - acc is SAMPLE_SIZE+COEFF_SIZE+$clog2(TAPS) bits, so it never wraps.
- Ring wrap-around is seamless. History persists across outputs and is cleared only by CLR.

## Timing
- Accepted sample completing a phase at edge t: MAC occupies t+1..t+TAPS, DRAIN t+TAPS+1, ROUND t+TAPS+2. y_valid is first high after edge t+TAPS+3, giving latency TAPS+3 cycles.
- The sample written at edge t is read correctly at t+1; no write/read hazard.
- s_ready is 0 from MAC until the OUT handshake completes. Minimum output period is DECIM + TAPS + 3 cycles.
- Non-final phase samples are accepted back-to-back, one per cycle.
- nrst asserted at any time, including mid-MAC or in OUT: y_valid drops immediately (async) and the state returns to CLR. No partial result is ever emitted.

## Test plan
- Reset with TAPS=4: s_ready stays 0 for exactly 4 cycles after nrst release, then 1; y_valid, y_dout and c_busy read 0/0/1 during CLR.
- TAPS=4, DECIM=2, OUT_SHIFT=1, coeffs {2,4,6,8}, samples 10,20: y_dout = 40 (20×2+10×4 = 80, rounded/shifted). Then 30,40: y_dout = 200 (400>>1). Check TAPS+3 latency from the second sample.
- Saturation: all coeffs 32767, four samples 32767 → y_dout = 32767, y_sat = 1. Samples −32768 → y_dout = −32768, y_sat = 1.
- Rounding, instance OUT_SHIFT=2, single tap coeff 1: acc 6 → 2; acc −6 → −1; acc 5 → 1.
- Backpressure: hold y_ready = 0 for 20 cycles → y_dout stable, s_ready = 0, an s_valid pulse is not written. Drop-in c_we during MAC → coefficient unchanged on the next output.
- Reset mid-MAC, then flush test: the next output after reset reflects only post-reset samples. flush with s_valid in IDLE → sample rejected, history zero.
